// File: rtl/add12u_share_arb.sv
// Round-robin arbiter time-sharing one 12-bit unsigned adder (exact or 0LB approximate)
// among NREQ valid/ready requesters, with a single registered, id-tagged result slot.
module add12u_share_arb #(
    parameter int NREQ   = 4,
    parameter int APPROX = 1,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [12*NREQ-1:0] req_a,
    input  logic [12*NREQ-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [12:0]        rsp_sum,
    output logic [IDW-1:0]     rsp_id,
    output logic [15:0]        grant_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [12:0]    sum_q, sum_d;
    logic [15:0]    cnt_q, cnt_d;

    logic           acc, found, xfer;
    logic [IDW-1:0] win;
    logic [11:0]    op_a, op_b;
    logic [12:0]    exact_sum, apx_sum, core_sum;
    int             idx;

    assign rsp_valid = (state_q == FULL);
    assign acc       = (state_q == EMPTY) | (rsp_ready & rsp_valid);

    // Rotating priority scan: first valid requester at or after ptr wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign xfer = !rst & acc & found;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[win] = 1'b1;
    end

    assign op_a = req_a[int'(win)*12 +: 12];
    assign op_b = req_b[int'(win)*12 +: 12];

    // 0LB variant: low nibble is wired from operand bits, A[3] feeds the upper adder as carry-in.
    always_comb begin
        exact_sum      = {1'b0, op_a} + {1'b0, op_b};
        apx_sum[12:4]  = {1'b0, op_a[11:4]} + {1'b0, op_b[11:4]} + {8'b0, op_a[3]};
        apx_sum[3:0]   = {op_b[3], op_b[2], op_a[1], op_b[1]};
        core_sum       = (APPROX != 0) ? apx_sum : exact_sum;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            state_d = FULL;
            sum_d   = core_sum;
            id_d    = win;
            ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
            cnt_d   = cnt_q + 16'd1;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_add12u_share_arb.sv
// Directed bench: exact and approximate instances share stimulus; expected values hand-derived.
module tb_add12u_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [12*NREQ-1:0] req_a, req_b;
    logic              rsp_ready;

    logic [NREQ-1:0]   ex_ready, ap_ready;
    logic              ex_valid, ap_valid;
    logic [12:0]       ex_sum, ap_sum;
    logic [IDW-1:0]    ex_id, ap_id;
    logic [15:0]       ex_cnt, ap_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [11:0] ta [NREQ] = '{12'h123, 12'h456, 12'h789, 12'hABC};
    logic [11:0] tb [NREQ] = '{12'hFFF, 12'h001, 12'h800, 12'h555};
    logic [12:0] held;

    always #5 clk = ~clk;

    add12u_share_arb #(.NREQ(NREQ), .APPROX(0), .IDW(IDW)) u_exact (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ex_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(ex_valid), .rsp_ready(rsp_ready),
        .rsp_sum(ex_sum), .rsp_id(ex_id), .grant_cnt(ex_cnt)
    );

    add12u_share_arb #(.NREQ(NREQ), .APPROX(1), .IDW(IDW)) u_apx (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ap_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(ap_valid), .rsp_ready(rsp_ready),
        .rsp_sum(ap_sum), .rsp_id(ap_id), .grant_cnt(ap_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
        req_a[i*12 +: 12] = a;
        req_b[i*12 +: 12] = b;
    endtask

    initial begin
        rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        #1;
        chk("rst_ready_comb", {28'b0, ex_ready}, 32'h0);
        // Reset with every requester valid
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_ready", {28'b0, ex_ready}, 32'h0);
            chk("rst_valid", {31'b0, ex_valid}, 32'h0);
            chk("rst_sum",   {19'b0, ex_sum}, 32'h0);
            chk("rst_cnt",   {16'b0, ex_cnt}, 32'h0);
        end
        rst = 1'b0;
        #1;
        chk("first_grant_req0", {28'b0, ex_ready}, 32'h1);

        // Exact single transfer from req 2 only
        req_valid = 4'b0100;
        set_op(2, 12'hFFF, 12'h001);
        #1;
        chk("single_valid_grant", {28'b0, ex_ready}, 32'h4);
        step();
        chk("ex_sum_fff_001", {19'b0, ex_sum}, 32'h1000);
        chk("ex_id_2",        {30'b0, ex_id},  32'h2);
        chk("ex_cnt_1",       {16'b0, ex_cnt}, 32'h1);
        chk("ex_valid_1",     {31'b0, ex_valid}, 32'h1);
        chk("ap_sum_fff_001", {19'b0, ap_sum}, 32'h1002);

        // Approximate function via req 0, ptr currently 3
        req_valid = 4'b0001;
        set_op(0, 12'h00A, 12'h006);
        step();
        chk("ap_sum_00a_006", {19'b0, ap_sum}, 32'h017);
        chk("ex_sum_00a_006", {19'b0, ex_sum}, 32'h010);
        chk("ap_id_0",        {30'b0, ap_id},  32'h0);
        set_op(0, 12'hFF8, 12'h008);
        step();
        chk("ap_sum_ff8_008", {19'b0, ap_sum}, 32'h1008);
        chk("ex_sum_ff8_008", {19'b0, ex_sum}, 32'h1000);
        chk("ap_cnt_3",       {16'b0, ap_cnt}, 32'h3);

        // Round-robin under saturation from a fresh reset
        rst = 1'b1; req_valid = '0;
        step();
        chk("rst2_valid", {31'b0, ex_valid}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, ta[i], tb[i]);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_id",  {30'b0, ex_id}, k % NREQ);
            chk("rr_sum", {19'b0, ex_sum}, {19'b0, 1'b0, ta[k % NREQ]} + {19'b0, 1'b0, tb[k % NREQ]});
        end
        chk("rr_cnt_8", {16'b0, ex_cnt}, 32'h8);

        // Backpressure: result held, no grants
        rsp_ready = 1'b0;
        held = 13'h1011;
        #1;
        chk("bp_ready_comb", {28'b0, ex_ready}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_ready", {28'b0, ex_ready}, 32'h0);
            chk("bp_valid", {31'b0, ex_valid}, 32'h1);
            chk("bp_id",    {30'b0, ex_id}, 32'h3);
            chk("bp_sum",   {19'b0, ex_sum}, {19'b0, held});
        end
        chk("bp_cnt", {16'b0, ex_cnt}, 32'h8);
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", {28'b0, ex_ready}, 32'h1);
        step();
        chk("bp_no_gap_valid", {31'b0, ex_valid}, 32'h1);
        chk("bp_no_gap_id",    {30'b0, ex_id}, 32'h0);
        chk("bp_no_gap_sum",   {19'b0, ex_sum}, 32'h1122);
        chk("bp_cnt_9",        {16'b0, ex_cnt}, 32'h9);

        // Counter wrap after 65536 transfers
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 65535; k++) step();
        chk("wrap_ffff", {16'b0, ex_cnt}, 32'hFFFF);
        step();
        chk("wrap_zero",    {16'b0, ex_cnt}, 32'h0);
        chk("wrap_ap_zero", {16'b0, ap_cnt}, 32'h0);
        chk("wrap_valid",   {31'b0, ex_valid}, 32'h1);
        step();
        chk("post_wrap_id", {30'b0, ex_id}, 32'h0);

        // Mid-operation reset while FULL with ptr at 1
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {28'b0, ex_ready}, 32'h0);
        step();
        chk("mid_rst_valid", {31'b0, ex_valid}, 32'h0);
        chk("mid_rst_sum",   {19'b0, ex_sum}, 32'h0);
        chk("mid_rst_cnt",   {16'b0, ex_cnt}, 32'h0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ptr0", {28'b0, ex_ready}, 32'h1);
        step();
        chk("mid_rst_id0", {30'b0, ex_id}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
